// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction RAM: assembles big-endian words, writes them
// at ascending addresses, verifies the trailing XOR checksum and holds the CPU meanwhile.
module imem_loader #(
    parameter int WIDTH    = 16,
    parameter int I_ADDR_W = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                mem_wr,
    output logic [I_ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_data,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [I_ADDR_W:0]   words_loaded
);

    localparam logic [15:0] CAPACITY = 16'(2 ** I_ADDR_W);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  acc;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [7:0]  hi_byte;
    logic        xfer;
    logic [15:0] len_word_in;
    logic [15:0] words_next;

    assign xfer        = in_valid & in_ready;
    assign len_word_in = {len_hi, in_data};
    assign words_next  = 16'(words_loaded) + 16'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (load_start) state_nxt = LEN_HI;
            LEN_HI:          if (xfer) state_nxt = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_word_in > CAPACITY)  state_nxt = ERR;
                    else if (len_word_in == 0)   state_nxt = CHECK;
                    else                         state_nxt = DATA_HI;
                end
            end
            DATA_HI:         if (xfer) state_nxt = DATA_LO;
            DATA_LO:         if (xfer) state_nxt = WRITE;
            WRITE:           state_nxt = (words_next == len) ? CHECK : DATA_HI;
            CHECK:           if (xfer) state_nxt = (in_data == acc) ? DONE : ERR;
            default:         state_nxt = IDLE;
        endcase
    end

    // in_ready and mem_wr are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            len_hi       <= '0;
            len          <= '0;
            hi_byte      <= '0;
            in_ready     <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK});
            mem_wr   <= (state_nxt == WRITE);

            if (xfer && state != CHECK)
                acc <= acc ^ in_data;

            case (state)
                IDLE, DONE, ERR: begin
                    if (load_start) begin
                        acc          <= '0;
                        words_loaded <= '0;
                        mem_addr     <= '0;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        cpu_hold     <= 1'b1;
                    end
                end
                LEN_HI:  if (xfer) len_hi <= in_data;
                LEN_LO: begin
                    if (xfer) begin
                        len <= len_word_in;
                        if (len_word_in > CAPACITY)
                            err <= 1'b1;
                    end
                end
                DATA_HI: if (xfer) hi_byte <= in_data;
                DATA_LO: begin
                    if (xfer) begin
                        mem_data <= {hi_byte, in_data};
                        mem_addr <= words_loaded[I_ADDR_W-1:0];
                    end
                end
                WRITE:   words_loaded <= words_loaded + 1'b1;
                CHECK: begin
                    if (xfer) begin
                        if (in_data == acc) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued as bytes are sent
// and popped when the loader pulses mem_wr.
module tb_imem_loader;

    localparam int WIDTH    = 16;
    localparam int I_ADDR_W = 7;
    localparam int CAP      = 2 ** I_ADDR_W;

    logic                clk = 1'b0;
    logic                reset;
    logic                load_start;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic                mem_wr;
    logic [I_ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_data;
    logic                cpu_hold;
    logic                done;
    logic                err;
    logic [I_ADDR_W:0]   words_loaded;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [15:0] img [0:CAP-1];
    int          exp_addr [$];
    logic [15:0] exp_data [$];
    logic        prev_wr;

    imem_loader #(.WIDTH(WIDTH), .I_ADDR_W(I_ADDR_W)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Every write must match the oldest queued word, last one cycle, and block the input
    always @(negedge clk) begin
        if (reset) begin
            prev_wr <= 1'b0;
        end else begin
            prev_wr <= mem_wr;
            if (mem_wr) begin
                checkOutput("wr_one_cycle", 32'(prev_wr), 0);
                checkOutput("ready_in_write", 32'(in_ready), 0);
                if (exp_addr.size() == 0) begin
                    checkOutput("unexpected_wr", 32'(mem_wr), 0);
                end else begin
                    checkOutput("wr_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                    checkOutput("wr_data", 32'(mem_data), 32'(exp_data.pop_front()));
                end
            end
        end
    end

    task automatic pulseStart();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checkOutput("start_ready", 32'(in_ready), 1);
        checkOutput("start_hold", 32'(cpu_hold), 1);
        checkOutput("start_done_clr", 32'({done, err}), 0);
    endtask

    // Called and returns at a negedge; in_ready is stable between edges
    task automatic sendByte(input logic [7:0] b, input bit rnd);
        int guard;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", 32'(in_ready), 1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input bit corrupt, input bit rnd);
        logic [7:0]  chk;
        logic [15:0] len;
        len = 16'(n);
        chk = len[15:8] ^ len[7:0];
        pulseStart();
        sendByte(len[15:8], rnd);
        sendByte(len[7:0], rnd);
        for (int i = 0; i < n; i++) begin
            chk = chk ^ img[i][15:8] ^ img[i][7:0];
            exp_addr.push_back(i);
            exp_data.push_back(img[i]);
            sendByte(img[i][15:8], rnd);
            sendByte(img[i][7:0], rnd);
        end
        sendByte(corrupt ? (chk ^ 8'h01) : chk, rnd);
        checkOutput("end_done", 32'(done), corrupt ? 0 : 1);
        checkOutput("end_err", 32'(err), corrupt ? 1 : 0);
        checkOutput("end_hold", 32'(cpu_hold), corrupt ? 1 : 0);
        checkOutput("end_words", 32'(words_loaded), 32'(n));
        checkOutput("end_ready", 32'(in_ready), 0);
        checkOutput("sb_empty", 32'(exp_addr.size()), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(in_ready), 0);
        checkOutput({tag, "_wr"}, 32'(mem_wr), 0);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 0);
        checkOutput({tag, "_data"}, 32'(mem_data), 0);
        checkOutput({tag, "_flags"}, 32'({cpu_hold, done, err}), 0);
        checkOutput({tag, "_words"}, 32'(words_loaded), 0);
    endtask

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkResetValues("rst");

        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);

        // Over-long image must abort right after the length with no writes
        pulseStart();
        sendByte(8'h00, 1'b0);
        sendByte(8'h81, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("len_err", 32'(err), 1);
        checkOutput("len_done", 32'(done), 0);
        checkOutput("len_ready", 32'(in_ready), 0);
        checkOutput("len_hold", 32'(cpu_hold), 1);
        checkOutput("len_words", 32'(words_loaded), 0);

        for (int i = 0; i < CAP; i++) img[i] = 16'($urandom);
        applyStimulus(CAP, 1'b0, 1'b1);

        // Reset while waiting for a low byte
        pulseStart();
        sendByte(8'h00, 1'b0);
        sendByte(8'h02, 1'b0);
        sendByte(8'h55, 1'b0);
        checkOutput("mid_ready", 32'(in_ready), 1);
        reset = 1'b1;
        #1;
        checkResetValues("midrst");
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        img[0] = 16'hBEEF;
        img[1] = 16'h0F0F;
        applyStimulus(2, 1'b0, 1'b1);

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
